// File: rtl/rx_pkg.sv
// rx_pkg: shared framing constants and FSM encoding for the RX drain arbiter.
package rx_pkg;
    localparam logic [15:0] START_WORD = 16'hDEAD;
    localparam logic [15:0] END_WORD = 16'hBEEF;
    localparam int DEFAULT_PKT_WORDS = 128;
    typedef enum logic [1:0] {IDLE, ARB, DRAIN, FLUSH} state_t;
endpackage

// File: rtl/rx_skid_buf2.sv
// rx_skid_buf2: two-entry valid/ready buffer; the head entry drives the output.
module rx_skid_buf2 #(
    parameter int W = 19
) (
    input  logic         DRAM_RD_clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic wr_ptr, rd_ptr, push, pop;

    assign out_valid = count != 2'd0;
    assign pop = out_valid && out_ready;
    assign push = in_valid && (count != 2'd2 || pop);
    assign out_data = mem[rd_ptr];

    always_ff @(posedge DRAM_RD_clk or negedge rst_n)
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
endmodule

// File: rtl/rx_drain_arbiter.sv
// rx_drain_arbiter: round-robin drain of per-link RX packet buffers into one
// 16-bit stream, with framing check, stall abort and backpressure absorption.
module rx_drain_arbiter
    import rx_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PKT_WORDS = DEFAULT_PKT_WORDS,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                       DRAM_RD_clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          buf_data_ready,
    input  logic [NUM_CH-1:0]          buf_empty,
    input  logic [NUM_CH*16-1:0]       buf_rd_data,
    output logic [NUM_CH-1:0]          buf_rd_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_data,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic                       out_err,
    output logic                       pkt_abort,
    output logic [15:0]                err_cnt,
    output logic                       busy
);
    localparam int CW = $clog2(NUM_CH);
    localparam int IW = $clog2(PKT_WORDS + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    state_t state, state_nxt;
    logic [CW-1:0] grant, last_grant, pick;
    logic [IW-1:0] issued, rcv;
    logic [SW-1:0] stall_cnt;
    logic [1:0] skid_cnt;
    logic [15:0] rd_word;
    logic [18:0] skid_in, skid_out;
    logic found, inflight, pkt_err, rd, abort, pop, drained, grab;
    logic word_sop, word_eop, word_err;

    function automatic logic [CW-1:0] wrap(input int v);
        return CW'(v % NUM_CH);
    endfunction

    // Descending scan so the nearest ready channel after last_grant wins.
    always_comb begin
        pick = '0;
        found = 1'b0;
        for (int k = NUM_CH; k >= 1; k--)
            if (buf_data_ready[wrap(int'(last_grant) + k)]) begin
                pick = wrap(int'(last_grant) + k);
                found = 1'b1;
            end
    end

    assign pop = out_valid && out_ready;
    assign grab = state == ARB && enable && found;
    // Credit: words already held plus the one landing now, minus the one leaving.
    assign rd = state == DRAIN && !buf_empty[grant] && issued < IW'(PKT_WORDS) &&
                (int'(skid_cnt) + int'(inflight) - int'(pop)) < 2;
    assign abort = state == DRAIN && buf_empty[grant] && stall_cnt == SW'(STALL_LIMIT - 1);
    assign drained = !inflight && (skid_cnt == 2'd0 || (skid_cnt == 2'd1 && pop));

    always_comb begin
        buf_rd_req = '0;
        buf_rd_req[grant] = rd;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = enable ? ARB : IDLE;
            ARB:     state_nxt = !enable ? IDLE : found ? DRAIN : ARB;
            DRAIN:   state_nxt = (abort || (rd && issued == IW'(PKT_WORDS - 1))) ? FLUSH : DRAIN;
            FLUSH:   state_nxt = !drained ? FLUSH : enable ? ARB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge DRAM_RD_clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;

    assign rd_word = buf_rd_data[16*grant +: 16];
    assign word_sop = rcv == '0;
    assign word_eop = rcv == IW'(PKT_WORDS - 1);
    assign word_err = word_eop && (pkt_err || rd_word != END_WORD);
    assign skid_in = {rd_word, word_sop, word_eop, word_err};

    always_ff @(posedge DRAM_RD_clk or negedge rst_n)
        if (!rst_n) begin
            grant <= '0;
            last_grant <= CW'(NUM_CH - 1);
            issued <= '0;
            rcv <= '0;
            stall_cnt <= '0;
            inflight <= 1'b0;
            pkt_err <= 1'b0;
            pkt_abort <= 1'b0;
            err_cnt <= '0;
        end else begin
            inflight <= rd;
            pkt_abort <= abort;
            if (rd)
                issued <= issued + 1'b1;
            stall_cnt <= rd ? '0 : (state == DRAIN && buf_empty[grant]) ? stall_cnt + 1'b1 : stall_cnt;
            if (inflight) begin
                rcv <= rcv + 1'b1;
                pkt_err <= pkt_err | (word_sop && rd_word != START_WORD);
            end
            if (((inflight && word_err) || abort) && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 1'b1;
            if (grab) begin
                grant <= pick;
                last_grant <= pick;
                issued <= '0;
                rcv <= '0;
                stall_cnt <= '0;
                pkt_err <= 1'b0;
            end
        end

    rx_skid_buf2 #(.W(19)) u_skid (
        .DRAM_RD_clk(DRAM_RD_clk),
        .rst_n(rst_n),
        .in_valid(inflight),
        .in_data(skid_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(skid_out),
        .count(skid_cnt)
    );

    assign {out_data, out_sop, out_eop, out_err} = skid_out;
    assign out_ch = grant;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_rx_drain_arbiter.sv
// tb_rx_drain_arbiter: randomized packet traffic against a per-channel stream
// scoreboard with round-robin, framing, abort and backpressure expectations.
module tb_rx_drain_arbiter;
    import rx_pkg::*;
    localparam int NUM_CH = 4;
    localparam int PKT_WORDS = 128;
    localparam int STALL_LIMIT = 1024;
    localparam int CW = $clog2(NUM_CH);

    logic DRAM_RD_clk = 1'b0;
    logic rst_n, enable, out_ready;
    logic [NUM_CH-1:0] buf_data_ready, buf_empty, buf_rd_req;
    logic [NUM_CH*16-1:0] buf_rd_data;
    logic out_valid, out_sop, out_eop, out_err, pkt_abort, busy;
    logic [15:0] out_data, err_cnt;
    logic [CW-1:0] out_ch;

    always #5 DRAM_RD_clk = ~DRAM_RD_clk;

    rx_drain_arbiter #(.NUM_CH(NUM_CH), .PKT_WORDS(PKT_WORDS), .STALL_LIMIT(STALL_LIMIT)) dut (
        .DRAM_RD_clk(DRAM_RD_clk), .rst_n(rst_n), .enable(enable),
        .buf_data_ready(buf_data_ready), .buf_empty(buf_empty), .buf_rd_data(buf_rd_data),
        .buf_rd_req(buf_rd_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .out_sop(out_sop), .out_eop(out_eop),
        .out_err(out_err), .pkt_abort(pkt_abort), .err_cnt(err_cnt), .busy(busy)
    );

    int checks = 0, errors = 0;
    logic [15:0] q[NUM_CH][$];
    logic [15:0] exp_w[NUM_CH][$];
    bit exp_bad[NUM_CH][$];
    int pkts_left[NUM_CH], pop_cnt[NUM_CH], hold_at[NUM_CH];
    logic [NUM_CH-1:0] req_pend;
    int ready_mode = 0, gap_pct = 0;
    int in_pkt = 0, cur_ch = 0, idx = 0, last_ch = NUM_CH - 1;
    bit cur_bad, was_stalled;
    logic [20:0] prev_vec;
    int exp_err = 0, n_req = 0, n_beat = 0, cyc = 0, pkts_done = 0, aborts = 0;
    int first_req_cyc = -1, busy_cyc = -1, sop_cyc = -1, eop_cyc = -1, last_req_cyc = -1, abort_cyc = -1;
    int sop_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int last);
        for (int k = 1; k <= NUM_CH; k++)
            if (pkts_left[(last + k) % NUM_CH] > 0)
                return (last + k) % NUM_CH;
        return -1;
    endfunction

    task automatic load(input int ch, input int kind);
        logic [15:0] w;
        for (int k = 0; k < PKT_WORDS; k++) begin
            w = 16'($urandom);
            if (k == 0) w = (kind == 1) ? 16'hDEAC : START_WORD;
            if (k == PKT_WORDS - 1) w = (kind == 2) ? 16'h1234 : END_WORD;
            q[ch].push_back(w);
            exp_w[ch].push_back(w);
        end
        exp_bad[ch].push_back(kind != 0);
        pkts_left[ch]++;
    endtask

    task automatic beat();
        int ch;
        n_beat++;
        if (in_pkt == 0) begin
            check("sop", out_sop, 1);
            ch = rr_pick(last_ch);
            check("rr_ch", 32'(out_ch), 32'(ch));
            cur_ch = (ch >= 0) ? ch : int'(out_ch);
            in_pkt = 1;
            idx = 0;
            last_ch = cur_ch;
            pkts_left[cur_ch]--;
            cur_bad = exp_bad[cur_ch].size() > 0 ? exp_bad[cur_ch].pop_front() : 1'b0;
            sop_log.push_back(cur_ch);
            sop_cyc = cyc;
        end else begin
            check("sop", out_sop, 0);
            check("ch_stable", 32'(out_ch), 32'(cur_ch));
        end
        if (exp_w[cur_ch].size() > 0)
            check("data", out_data, exp_w[cur_ch].pop_front());
        else
            check("data_extra", 1, 0);
        check("eop", out_eop, idx == PKT_WORDS - 1);
        if (idx == PKT_WORDS - 1) begin
            check("err", out_err, cur_bad);
            exp_err += int'(cur_bad);
            in_pkt = 0;
            pkts_done++;
            eop_cyc = cyc;
        end
        idx++;
    endtask

    task automatic tick();
        @(negedge DRAM_RD_clk);
        cyc++;
        for (int i = 0; i < NUM_CH; i++)
            if (req_pend[i] && q[i].size() > 0) begin
                buf_rd_data[16*i +: 16] = q[i].pop_front();
                pop_cnt[i]++;
            end
        for (int i = 0; i < NUM_CH; i++) begin
            buf_data_ready[i] = q[i].size() >= PKT_WORDS;
            buf_empty[i] = q[i].size() == 0 || pop_cnt[i] >= hold_at[i] ||
                           (gap_pct > 0 && $urandom_range(99) < gap_pct);
        end
        out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? !out_ready : ($urandom_range(99) < 60);
        #1;
        if (buf_rd_req != 0) begin
            check("req_onehot", $countones(buf_rd_req), 1);
            check("req_on_empty", 32'(buf_rd_req & buf_empty), 0);
            n_req += $countones(buf_rd_req);
            last_req_cyc = cyc;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        req_pend = buf_rd_req;
        if (was_stalled)
            check("hold_stable", {out_valid, out_data, out_ch, out_sop, out_eop, out_err}, {1'b1, prev_vec});
        was_stalled = out_valid && !out_ready;
        prev_vec = {out_data, out_ch, out_sop, out_eop, out_err};
        if (busy && busy_cyc < 0) busy_cyc = cyc;
        if (out_valid && out_ready) beat();
        if (buf_rd_req != 0) check("outstanding", n_req - n_beat <= 2, 1);
        if (pkt_abort) begin
            aborts++;
            exp_err++;
            abort_cyc = cyc;
            if (in_pkt != 0) begin
                for (int k = idx; k < PKT_WORDS; k++)
                    if (exp_w[cur_ch].size() > 0) void'(exp_w[cur_ch].pop_front());
                in_pkt = 0;
            end
        end
    endtask

    task automatic run_pkts(input int target, input int budget);
        int n = 0;
        while (pkts_done < target && n < budget) begin
            tick();
            n++;
        end
        check("pkt_timeout", pkts_done, target);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req"}, 32'(buf_rd_req), 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_ch"}, 32'(out_ch), 0);
        check({tag, "_flags"}, {out_sop, out_eop, out_err}, 0);
        check({tag, "_abort"}, pkt_abort, 0);
        check({tag, "_errcnt"}, err_cnt, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            q[i].delete();
            exp_w[i].delete();
            exp_bad[i].delete();
            pkts_left[i] = 0;
            hold_at[i] = 1 << 30;
        end
        in_pkt = 0;
        last_ch = NUM_CH - 1;
        exp_err = 0;
        req_pend = '0;
        n_req = 0;
        n_beat = 0;
        was_stalled = 0;
    endtask

    initial begin
        int n, base, tot;
        rst_n = 1'b0;
        enable = 1'b0;
        out_ready = 1'b1;
        buf_data_ready = '0;
        buf_empty = '1;
        buf_rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) pop_cnt[i] = 0;
        model_clear();
        repeat (3) tick();
        reset_checks("rst");
        rst_n = 1'b1;
        tick();

        // Single good packet on channel 2
        load(2, 0);
        enable = 1'b1;
        run_pkts(1, 400);
        check("t1_ch", sop_log[0], 2);
        check("t1_arb_to_req", first_req_cyc - busy_cyc, 1);
        check("t1_req_to_sop", sop_cyc - first_req_cyc, 2);
        check("t1_burst", eop_cyc - sop_cyc, PKT_WORDS - 1);
        check("t1_pkt_cycles", eop_cyc - busy_cyc, PKT_WORDS + 2);
        check("t1_errcnt", err_cnt, 0);

        // Make last_grant 0, then ch0 and ch3 contend: ch3 wins
        load(0, 0);
        run_pkts(2, 400);
        load(0, 0);
        load(3, 0);
        run_pkts(4, 800);
        check("t2_first", sop_log[2], 3);
        check("t2_second", sop_log[3], 0);

        // out_ready toggling every cycle
        ready_mode = 1;
        base = n_beat;
        load(1, 0);
        run_pkts(5, 800);
        check("t3_beats", n_beat - base, PKT_WORDS);
        ready_mode = 0;

        // Framing errors: bad end word, then bad start word
        load(3, 2);
        run_pkts(6, 400);
        check("t4_errcnt_end", err_cnt, 1);
        load(0, 1);
        run_pkts(7, 400);
        check("t4_errcnt_start", err_cnt, exp_err);

        // Stall from word 60 on ch1 aborts; ch2 is served next
        hold_at[1] = pop_cnt[1] + 60;
        load(1, 0);
        load(2, 0);
        n = 0;
        while (aborts == 0 && n < STALL_LIMIT + 400) begin
            tick();
            n++;
        end
        check("t5_abort_seen", aborts, 1);
        check("t5_abort_delay", abort_cyc - last_req_cyc, STALL_LIMIT + 1);
        q[1].delete();
        hold_at[1] = 1 << 30;
        tick();
        check("t5_abort_pulse", pkt_abort, 0);
        check("t5_errcnt", err_cnt, exp_err);
        run_pkts(8, 400);
        check("t5_next_ch", sop_log[sop_log.size() - 1], 2);

        // Enable dropped at word 10 of ch0: finish, then idle
        load(0, 0);
        load(1, 0);
        n = 0;
        while (!(in_pkt != 0 && idx >= 10) && n < 400) begin
            tick();
            n++;
        end
        enable = 1'b0;
        run_pkts(9, 400);
        repeat (3) tick();
        check("t6_busy", busy, 0);
        base = n_req;
        repeat (20) tick();
        check("t6_no_grant", n_req - base, 0);
        check("t6_ch1_waiting", pkts_left[1], 1);

        // Asynchronous reset mid-DRAIN
        enable = 1'b1;
        n = 0;
        while (!(in_pkt != 0 && idx >= 5) && n < 400) begin
            tick();
            n++;
        end
        check("t6_ch1_running", in_pkt, 1);
        #2 rst_n = 1'b0;
        #1 reset_checks("arst");
        model_clear();
        tick();
        rst_n = 1'b1;

        // Randomized traffic with backpressure and short empty gaps
        ready_mode = 2;
        gap_pct = 10;
        for (int r = 0; r < 6; r++) begin
            tot = 0;
            for (int i = 0; i < NUM_CH; i++)
                for (int p = $urandom_range(2); p > 0; p--) begin
                    load(i, $urandom_range(9) == 0 ? int'($urandom_range(1, 2)) : 0);
                    tot++;
                end
            run_pkts(pkts_done + tot, 3000);
            repeat (4) tick();
            check("rand_errcnt", err_cnt, exp_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
